// File: rtl/wave_lut_mc.sv
// wave_lut_mc: multi-channel wave lookup (pulse / LFSR noise / double-banked table).
// Each channel turns its phase address and 4-bit wave type into a registered sample.
// Optional feature macro: NOISE_SHORT_EN enables the per-channel short-period
// (127-step) noise polynomial selected by noise_short_in.
module wave_lut_mc #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 5,
  parameter int SAMPLE_W = 4,
  parameter int OUT_W    = 16,
  parameter int SYNC_CH  = 0
) (
  input  logic                         clk_in,
  input  logic                         reset_n_in,
  input  logic [CHANNELS*ADDR_W-1:0]   lut_addr_in,
  input  logic [CHANNELS*4-1:0]        wave_type_in,
  input  logic [CHANNELS-1:0]          noise_short_in,
  input  logic [ADDR_W-1:0]            mem_write_addr_in,
  input  logic [SAMPLE_W-1:0]          mem_write_data_in,
  input  logic                         mem_write_en_in,
  input  logic                         commit_in,
  output logic                         commit_pending_out,
  output logic                         active_bank_out,
  output logic [CHANNELS*OUT_W-1:0]    data_out
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PAD_W = OUT_W - SAMPLE_W;

  // Long-period step: x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic [15:0] lfsr_long(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Short-period step: only the low 7 bits circulate (period 127).
  function automatic logic [15:0] lfsr_short(input logic [15:0] v);
    return {v[15:7], v[5:0], v[6] ^ v[5]};
  endfunction

  // Table address translation selected by type bits [1:0].
  function automatic logic [ADDR_W-1:0] xlate(input logic [1:0] mode, input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    case (mode)
      2'd0:    r = a;
      2'd1:    r = {1'b0, a[ADDR_W-1:1]};
      2'd2:    r = {1'b1, a[ADDR_W-1:1]};
      2'd3:    r = {a[0], a[ADDR_W-1:1]};
      default: r = a;
    endcase
    return r;
  endfunction

  // Two banks, indexed {bank, addr}. Deliberately not reset.
  logic [SAMPLE_W-1:0]         mem_q [0:2*DEPTH-1];

  logic                        active_bank_q, active_bank_d;
  logic                        pending_q, pending_d;
  logic                        wrap_s, swap_s, read_bank_s;
  logic [CHANNELS*ADDR_W-1:0]  prev_addr_all_s;

`ifndef NOISE_SHORT_EN
  // Short-noise select has no function in this build.
  logic noise_short_unused_s;
  assign noise_short_unused_s = ^noise_short_in;
`endif

  // Bank swap control: arm on commit, swap on the SYNC_CH wrap edge.
  always_comb begin
    wrap_s        = (prev_addr_all_s[SYNC_CH*ADDR_W +: ADDR_W] == {ADDR_W{1'b1}}) &&
                    (lut_addr_in[SYNC_CH*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}});
    swap_s        = pending_q && wrap_s;
    active_bank_d = active_bank_q;
    pending_d     = pending_q;
    if (swap_s) begin
      active_bank_d = ~active_bank_q;
      pending_d     = 1'b0;
    end else if (commit_in) begin
      pending_d     = 1'b1;
    end else begin
      pending_d     = pending_q;
    end
    // The wrap-cycle sample already comes from the newly active bank.
    read_bank_s   = active_bank_q ^ swap_s;
  end

  // Bank state registers.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      active_bank_q <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      active_bank_q <= active_bank_d;
      pending_q     <= pending_d;
    end
  end

  // Table writes always target the shadow bank as registered before this edge.
  always_ff @(posedge clk_in) begin
    if (mem_write_en_in) begin
      mem_q[{~active_bank_q, mem_write_addr_in}] <= mem_write_data_in;
    end
  end

  assign commit_pending_out = pending_q;
  assign active_bank_out    = active_bank_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [ADDR_W-1:0]   addr_s, raddr_s;
    logic [3:0]          type_s;
    logic [SAMPLE_W-1:0] smp_s, tab_s;
    logic [ADDR_W-1:0]   prev_addr_q, prev_addr_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [OUT_W-1:0]    sample_q, sample_d;

    // Per-channel sample selection and noise stepping.
    always_comb begin
      addr_s      = lut_addr_in[g*ADDR_W +: ADDR_W];
      type_s      = wave_type_in[g*4 +: 4];
      raddr_s     = xlate(type_s[1:0], addr_s);
      smp_s       = mem_q[{read_bank_s, raddr_s}];
      tab_s       = type_s[2] ? ~smp_s : smp_s;
      prev_addr_d = addr_s;
      lfsr_d      = lfsr_q;
      sample_d    = {OUT_W{1'b0}};

      if (addr_s != prev_addr_q) begin
`ifdef NOISE_SHORT_EN
        if (noise_short_in[g]) begin
          lfsr_d = lfsr_short(lfsr_q);
        end else begin
          lfsr_d = lfsr_long(lfsr_q);
        end
`else
        lfsr_d = lfsr_long(lfsr_q);
`endif
      end else begin
        lfsr_d = lfsr_q;
      end

      if (type_s[3]) begin
        sample_d = OUT_W'(tab_s) << PAD_W;
      end else if (type_s[2:0] == 3'd7) begin
        sample_d = {{(OUT_W-1){1'b0}}, lfsr_q[0]};
      end else if (addr_s[ADDR_W-1 -: 3] >= (3'd7 - type_s[2:0])) begin
        sample_d = {{(OUT_W-1){1'b0}}, 1'b1};
      end else begin
        sample_d = {OUT_W{1'b0}};
      end
    end

    // Per-channel registers: previous address, noise state, output sample.
    always_ff @(posedge clk_in) begin
      if (!reset_n_in) begin
        prev_addr_q <= {ADDR_W{1'b0}};
        lfsr_q      <= 16'hFFFF;
        sample_q    <= {OUT_W{1'b0}};
      end else begin
        prev_addr_q <= prev_addr_d;
        lfsr_q      <= lfsr_d;
        sample_q    <= sample_d;
      end
    end

    assign prev_addr_all_s[g*ADDR_W +: ADDR_W] = prev_addr_q;
    assign data_out[g*OUT_W +: OUT_W]          = sample_q;
  end

endmodule

// File: tb/tb_wave_lut_mc.sv
// tb_wave_lut_mc: directed, table-driven bench for wave_lut_mc (default parameters).
module tb_wave_lut_mc;
  localparam int CH = 4;
  localparam int AW = 5;
  localparam int SW = 4;
  localparam int OW = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    wtype;
    logic [OW-1:0] exp;
  } vec_t;

  logic              clk_in = 1'b0;
  logic              reset_n_in;
  logic [CH*AW-1:0]  lut_addr_in;
  logic [CH*4-1:0]   wave_type_in;
  logic [CH-1:0]     noise_short_in;
  logic [AW-1:0]     mem_write_addr_in;
  logic [SW-1:0]     mem_write_data_in;
  logic              mem_write_en_in;
  logic              commit_in;
  logic              commit_pending_out;
  logic              active_bank_out;
  logic [CH*OW-1:0]  data_out;

  int n_cmp = 0;
  int n_bad = 0;

  wave_lut_mc dut (
    .clk_in             (clk_in),
    .reset_n_in         (reset_n_in),
    .lut_addr_in        (lut_addr_in),
    .wave_type_in       (wave_type_in),
    .noise_short_in     (noise_short_in),
    .mem_write_addr_in  (mem_write_addr_in),
    .mem_write_data_in  (mem_write_data_in),
    .mem_write_en_in    (mem_write_en_in),
    .commit_in          (commit_in),
    .commit_pending_out (commit_pending_out),
    .active_bank_out    (active_bank_out),
    .data_out           (data_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] ch_out(input int c);
    return data_out[c*OW +: OW];
  endfunction

  task automatic set_ch(input int c, input logic [AW-1:0] a, input logic [3:0] t);
    lut_addr_in[c*AW +: AW] = a;
    wave_type_in[c*4 +: 4]  = t;
  endtask

  task automatic set_all(input logic [AW-1:0] a, input logic [3:0] t);
    for (int c = 0; c < CH; c++) set_ch(c, a, t);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [SW-1:0] d);
    mem_write_addr_in = a;
    mem_write_data_in = d;
    mem_write_en_in   = 1'b1;
    tick();
    mem_write_en_in   = 1'b0;
  endtask

  task automatic commit_pulse();
    commit_in = 1'b1;
    tick();
    commit_in = 1'b0;
  endtask

  function automatic vec_t mk(input logic [AW-1:0] a, input logic [3:0] t, input logic [OW-1:0] e);
    vec_t v;
    v.addr = a; v.wtype = t; v.exp = e;
    return v;
  endfunction

  // Reference long-polynomial noise step.
  function automatic logic [15:0] ref_long(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return (v << 1) | {15'd0, fb};
  endfunction

  vec_t pv[$];
  vec_t tv[$];

  initial begin
    logic [15:0] lfsr;
    logic [AW-1:0] na;
    logic [OW-1:0] held;
    bit moved;

    // Pulse vectors: sweeps for types 1 and 3, plus threshold pairs for other duties.
    for (int a = 0; a < 32; a++) pv.push_back(mk(AW'(a), 4'h1, (a >= 24) ? 16'd1 : 16'd0));
    for (int a = 0; a < 32; a++) pv.push_back(mk(AW'(a), 4'h3, (a >= 16) ? 16'd1 : 16'd0));
    pv.push_back(mk(5'd27, 4'h0, 16'd0)); pv.push_back(mk(5'd28, 4'h0, 16'd1));
    pv.push_back(mk(5'd19, 4'h2, 16'd0)); pv.push_back(mk(5'd20, 4'h2, 16'd1));
    pv.push_back(mk(5'd11, 4'h4, 16'd0)); pv.push_back(mk(5'd12, 4'h4, 16'd1));
    pv.push_back(mk(5'd7,  4'h5, 16'd0)); pv.push_back(mk(5'd8,  4'h5, 16'd1));
    pv.push_back(mk(5'd3,  4'h6, 16'd0)); pv.push_back(mk(5'd4,  4'h6, 16'd1));

    // Table vectors, bank 1 active: entry i holds i[3:0], entry 20 rewritten to 9.
    tv.push_back(mk(5'd5,  4'h8, 16'h5000));
    tv.push_back(mk(5'd5,  4'hC, 16'hA000));
    tv.push_back(mk(5'd3,  4'hB, 16'h1000));
    tv.push_back(mk(5'd8,  4'h9, 16'h4000));
    tv.push_back(mk(5'd8,  4'hA, 16'h9000));
    tv.push_back(mk(5'd9,  4'hB, 16'h9000));
    tv.push_back(mk(5'd8,  4'hB, 16'h4000));
    tv.push_back(mk(5'd20, 4'h8, 16'h9000));
    tv.push_back(mk(5'd8,  4'hE, 16'h6000));
    tv.push_back(mk(5'd30, 4'hD, 16'h0000));

    // Reset with a commit request that must be dropped.
    reset_n_in        = 1'b0;
    lut_addr_in       = '0;
    wave_type_in      = '0;
    noise_short_in    = '0;
    mem_write_addr_in = '0;
    mem_write_data_in = '0;
    mem_write_en_in   = 1'b0;
    commit_in         = 1'b1;
    repeat (3) tick();
    for (int c = 0; c < CH; c++) check($sformatf("reset_data_ch%0d", c), ch_out(c), 16'h0000);
    check("reset_bank", 16'(active_bank_out), 16'd0);
    check("reset_pending", 16'(commit_pending_out), 16'd0);
    commit_in  = 1'b0;
    reset_n_in = 1'b1;
    tick();
    check("commit_in_reset_dropped", 16'(commit_pending_out), 16'd0);

    // Pulse duties on all channels.
    foreach (pv[i]) begin
      set_all(pv[i].addr, pv[i].wtype);
      tick();
      for (int c = 0; c < CH; c++)
        check($sformatf("pulse_t%0h_a%0d_ch%0d", pv[i].wtype, pv[i].addr, c), ch_out(c), pv[i].exp);
    end

    // Fill shadow bank 1, commit, swap on 31->0 with a coinciding write.
    set_all(5'd0, 4'h8);
    for (int i = 0; i < 32; i++) wr(AW'(i), SW'(i));
    commit_pulse();
    check("pending_rise", 16'(commit_pending_out), 16'd1);
    set_all(5'd31, 4'h8);
    tick();
    check("pre_wrap_bank", 16'(active_bank_out), 16'd0);
    set_all(5'd0, 4'h8);
    mem_write_addr_in = 5'd20;
    mem_write_data_in = 4'd9;
    mem_write_en_in   = 1'b1;
    tick();
    mem_write_en_in   = 1'b0;
    check("swap1_bank", 16'(active_bank_out), 16'd1);
    check("swap1_pending", 16'(commit_pending_out), 16'd0);
    check("swap1_wrap_sample_ch0", ch_out(0), 16'h0000);
    check("swap1_wrap_sample_ch3", ch_out(3), 16'h0000);

    foreach (tv[i]) begin
      set_all(tv[i].addr, tv[i].wtype);
      tick();
      check($sformatf("table_t%0h_a%0d_ch0", tv[i].wtype, tv[i].addr), ch_out(0), tv[i].exp);
      check($sformatf("table_t%0h_a%0d_ch2", tv[i].wtype, tv[i].addr), ch_out(2), tv[i].exp);
    end

    // Fill bank 0 with ~i, commit with SYNC address frozen at 7.
    set_all(5'd7, 4'h8);
    for (int i = 0; i < 32; i++) wr(AW'(i), ~SW'(i));
    commit_pulse();
    moved = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (active_bank_out !== 1'b1 || commit_pending_out !== 1'b1) moved = 1'b1;
    end
    check("frozen_no_swap", 16'(moved), 16'd0);
    commit_pulse();
    check("second_commit_pending", 16'(commit_pending_out), 16'd1);
    check("second_commit_bank", 16'(active_bank_out), 16'd1);
    set_all(5'd31, 4'h8);
    tick();
    check("step31_bank", 16'(active_bank_out), 16'd1);
    set_all(5'd0, 4'h8);
    tick();
    check("swap2_bank", 16'(active_bank_out), 16'd0);
    check("swap2_pending", 16'(commit_pending_out), 16'd0);
    check("swap2_wrap_sample", ch_out(0), 16'hF000);
    set_all(5'd5, 4'h8);
    tick();
    check("bank0_a5", ch_out(0), 16'hA000);

    // Mid-operation reset with bank 1 active and a commit pending.
    commit_pulse();
    set_all(5'd31, 4'h8);
    tick();
    set_all(5'd0, 4'h8);
    tick();
    check("swap3_bank", 16'(active_bank_out), 16'd1);
    commit_pulse();
    check("pre_reset_pending", 16'(commit_pending_out), 16'd1);
    reset_n_in = 1'b0;
    tick();
    reset_n_in = 1'b1;
    for (int c = 0; c < CH; c++) check($sformatf("midreset_data_ch%0d", c), ch_out(c), 16'h0000);
    check("midreset_bank", 16'(active_bank_out), 16'd0);
    check("midreset_pending", 16'(commit_pending_out), 16'd0);
    set_all(5'd5, 4'h8);
    tick();
    check("kept_bank0_a5", ch_out(0), 16'hA000);
    set_all(5'd20, 4'h8);
    tick();
    check("kept_bank0_a20", ch_out(0), 16'hB000);

    // Long-polynomial noise on ch1 from reset.
`ifdef NOISE_SHORT_EN
    noise_short_in = '0;
`else
    noise_short_in = '1;
`endif
    reset_n_in = 1'b0;
    set_all(5'd0, 4'h0);
    set_ch(1, 5'd0, 4'h7);
    repeat (2) tick();
    reset_n_in = 1'b1;
    lfsr = 16'hFFFF;
    na   = 5'd0;
    for (int n = 0; n < 40; n++) begin
      na = na + 5'd1;
      set_ch(1, na, 4'h7);
      tick();
      check($sformatf("noise_step%0d", n), ch_out(1), {15'd0, lfsr[0]});
      lfsr = ref_long(lfsr);
    end
    held = {15'd0, lfsr[0]};
    for (int n = 0; n < 6; n++) begin
      tick();
      check($sformatf("noise_hold%0d", n), ch_out(1), held);
    end
    for (int n = 0; n < 12; n++) begin
      na = na + 5'd1;
      set_ch(1, na, 4'h7);
      tick();
      check($sformatf("noise_resume%0d", n), ch_out(1), {15'd0, lfsr[0]});
      lfsr = ref_long(lfsr);
    end

`ifdef NOISE_SHORT_EN
    // Short noise: output bit repeats after 127 steps.
    begin
      logic [OW-1:0] seq [0:159];
      noise_short_in = 4'b0010;
      reset_n_in = 1'b0;
      set_ch(1, 5'd0, 4'h7);
      repeat (2) tick();
      reset_n_in = 1'b1;
      na = 5'd0;
      for (int n = 0; n < 160; n++) begin
        na = na + 5'd1;
        set_ch(1, na, 4'h7);
        tick();
        seq[n] = ch_out(1);
      end
      for (int n = 0; n < 30; n++)
        check($sformatf("short_period%0d", n), seq[n+127], seq[n]);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
